// File: rtl/shift_register_controller_pkg.sv
// sr_ctrl_pkg: shared types, constants and helpers for the shift-register controller.
// Holds the FSM state enum, the shift-direction encodings and the shift-count clamp.
// Imported by the controller top and its step counter.
package sr_ctrl_pkg;

  // PARITY is reachable only in builds with SR_CTRL_PARITY_EN defined.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PARITY,
    DRAIN,
    CLEAR
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;  // LSB leaves the register first
  localparam logic DIR_LEFT  = 1'b1;  // MSB leaves the register first

  // A register of maxCount bits can only shift maxCount meaningful bits out.
  function automatic int unsigned clamp_count(input int unsigned count,
                                              input int unsigned maxCount);
    return (count > maxCount) ? maxCount : count;
  endfunction

endpackage

// File: rtl/shift_register_controller_if.sv
// shift_register_controller_if: request, register-command and serial-return signals.
// master = controller side (drives ReqReady, Reg*, Serial*, Done);
// slave  = environment side (command source plus the shift-register datapath).
interface shift_register_controller_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             ReqValid;
  logic             ReqReady;
  logic [WIDTH-1:0] ReqData;
  logic             ReqDir;
  logic [CNT_W-1:0] ReqCount;
  logic             ReqFill;
  logic             Abort;
  logic             RegClear;
  logic             RegLoad;
  logic             RegShiftRight;
  logic             RegShiftLeft;
  logic             RegShiftIn;
  logic [WIDTH-1:0] RegData;
  logic             RegShiftOut;
  logic             SerialValid;
  logic             SerialBit;
  logic             Done;

  modport master (
    input  ReqValid, ReqData, ReqDir, ReqCount, ReqFill, Abort, RegShiftOut,
    output ReqReady, RegClear, RegLoad, RegShiftRight, RegShiftLeft, RegShiftIn,
           RegData, SerialValid, SerialBit, Done
  );

  modport slave (
    output ReqValid, ReqData, ReqDir, ReqCount, ReqFill, Abort, RegShiftOut,
    input  ReqReady, RegClear, RegLoad, RegShiftRight, RegShiftLeft, RegShiftIn,
           RegData, SerialValid, SerialBit, Done
  );

endinterface

// File: rtl/shift_register_controller_step_counter.sv
// sr_step_counter: loadable down-counter tracking the remaining shift steps.
// Latency: load/decrement take effect on the next rising edge; flags are combinational.
// Backpressure: none; holds at zero rather than wrapping.
// Ports: clockPulse/ResetN, load+loadValue, decrement, isOne/isZero flags.
module sr_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clockPulse,
  input  logic             ResetN,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             decrement,
  output logic             isOne,
  output logic             isZero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clockPulse or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign isOne  = (count == CNT_W'(1));
  assign isZero = (count == '0);

endmodule

// File: rtl/shift_register_controller.sv
// shift_register_controller: sequences one load then N shifts of the shift register per request.
// Latency: accept -> LOAD next cycle; Done N+2 cycles after accept (N+3 with parity).
// Backpressure: ReqReady high only in IDLE; one transfer in flight, no queueing.
// Ports: clockPulse, ResetN (async, active low), bus (master modport: Req*, Abort, Reg*, Serial*, Done).
// Optional: define SR_CTRL_PARITY_EN to append an even-parity bit after the data bits.
module shift_register_controller
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                        clockPulse,
  input logic                        ResetN,
  shift_register_controller_if.master bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SR_CTRL_PARITY_EN
  localparam state_t AFTER_SHIFT = PARITY;
`else
  localparam state_t AFTER_SHIFT = DRAIN;
`endif

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] dataQ;
  logic             dirQ;
  logic             fillQ;
  logic             serialValidQ;
  logic             accept;
  logic             stepIsOne;
  logic             stepIsZero;
  logic [CNT_W-1:0] clampedCount;

  assign accept       = (state == IDLE) && bus.ReqValid;
  assign clampedCount = CNT_W'(clamp_count(32'(bus.ReqCount), WIDTH));

  sr_step_counter #(.CNT_W(CNT_W)) stepCounter (
    .clockPulse (clockPulse),
    .ResetN     (ResetN),
    .load       (accept),
    .loadValue  (clampedCount),
    .decrement  (state == SHIFT),
    .isOne      (stepIsOne),
    .isZero     (stepIsZero)
  );

  always_ff @(posedge clockPulse or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState         = state;
    bus.ReqReady      = 1'b0;
    bus.RegClear      = 1'b0;
    bus.RegLoad       = 1'b0;
    bus.RegShiftRight = 1'b0;
    bus.RegShiftLeft  = 1'b0;
    bus.RegShiftIn    = 1'b0;
    bus.Done          = 1'b0;
    case (state)
      IDLE: begin
        bus.ReqReady = 1'b1;
        // Abort is ignored here, so a request arriving with Abort still starts.
        if (bus.ReqValid) nextState = LOAD;
      end
      LOAD: begin
        bus.RegLoad = 1'b1;
        if (bus.Abort)      nextState = CLEAR;
        else if (stepIsZero) nextState = AFTER_SHIFT;
        else                nextState = SHIFT;
      end
      SHIFT: begin
        bus.RegShiftRight = (dirQ == DIR_RIGHT);
        bus.RegShiftLeft  = (dirQ == DIR_LEFT);
        bus.RegShiftIn    = fillQ;
        if (bus.Abort)     nextState = CLEAR;
        else if (stepIsOne) nextState = AFTER_SHIFT;
      end
      PARITY: begin
        nextState = bus.Abort ? CLEAR : DRAIN;
      end
      DRAIN: begin
        // An aborted transfer never reports completion, even on its final cycle.
        bus.Done  = !bus.Abort;
        nextState = bus.Abort ? CLEAR : IDLE;
      end
      CLEAR: begin
        bus.RegClear = 1'b1;
        nextState    = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clockPulse or negedge ResetN) begin
    if (!ResetN) begin
      dataQ        <= '0;
      dirQ         <= 1'b0;
      fillQ        <= 1'b0;
      serialValidQ <= 1'b0;
    end else begin
      if (accept) begin
        dataQ <= bus.ReqData;
        dirQ  <= bus.ReqDir;
        fillQ <= bus.ReqFill;
      end
      // The register's ShiftOutput settles one cycle after each shift command.
      // PARITY also sets it so the parity bit in DRAIN is flagged valid.
      serialValidQ <= ((state == SHIFT) || (state == PARITY)) && (nextState != CLEAR);
    end
  end

  assign bus.RegData     = dataQ;
  assign bus.SerialValid = serialValidQ;

`ifdef SR_CTRL_PARITY_EN
  logic parityAcc;

  always_ff @(posedge clockPulse or negedge ResetN) begin
    if (!ResetN) begin
      parityAcc <= 1'b0;
    end else if (accept) begin
      parityAcc <= 1'b0;
    end else if (serialValidQ && (state != DRAIN)) begin
      parityAcc <= parityAcc ^ bus.RegShiftOut;
    end
  end

  assign bus.SerialBit = (state == DRAIN) ? parityAcc : bus.RegShiftOut;
`else
  assign bus.SerialBit = bus.RegShiftOut;
`endif

endmodule

// File: doc/shift_register_controller.md
Name: shift_register_controller

Overview:
- Sequencer for the 4-bit parallel-load / bidirectional shift register.
- Accepts a word-transfer request over a valid/ready handshake, then drives the register: one load cycle, then N shift cycles in the requested direction.
- Returns each shifted-out bit on a serial valid/bit pair and pulses Done at the end.
- Sits between a command source (CPU or test FSM) and the shift-register datapath; it is that register's only master.

Parameters:
- WIDTH, 4, register width in bits; must match the controlled register.
- CNT_W, $clog2(WIDTH+1), width of the shift-count fields.

Ports:
- clockPulse  in  1  single clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller idle and able to accept.
- ReqData  in  WIDTH  word to load.
- ReqDir  in  1  0 = shift right (LSB first), 1 = shift left (MSB first).
- ReqCount  in  CNT_W  number of shifts.
- ReqFill  in  1  bit fed into ShiftInput during shifts.
- Abort  in  1  cancel the current transfer.
- RegClear  out  1  drives the register's synchronous Reset.
- RegLoad  out  1  drives ParallelLoad.
- RegShiftRight  out  1  drives ShiftRight.
- RegShiftLeft  out  1  drives ShiftLeft.
- RegShiftIn  out  1  drives ShiftInput.
- RegData  out  WIDTH  drives Data.
- RegShiftOut  in  1  from the register's ShiftOutput.
- SerialValid  out  1  SerialBit is valid this cycle.
- SerialBit  out  1  shifted-out bit.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE; ReqReady=1; all Reg* outputs 0; RegData=0; SerialValid=0; Done=0; latched fields 0.
- States: IDLE, LOAD, SHIFT, DRAIN, CLEAR.
- Reg* commands and ReqReady are Moore outputs decoded from state and latched registers.
- Handshake: a request is accepted in IDLE when ReqValid=1 (ReqReady=1 only in IDLE).
  - ReqData, ReqDir, ReqFill are latched on acceptance.
  - ReqCount is latched clamped to WIDTH: a value >WIDTH becomes WIDTH.
- Timeline for accept at cycle 0, count N≥1:
  - Cycle 1: LOAD, RegLoad=1, RegData=latched word.
  - Cycles 2..N+1: SHIFT, exactly one of RegShiftRight/RegShiftLeft=1 per ReqDir; RegShiftIn=ReqFill.
  - Cycle N+2: DRAIN. Cycle N+3: IDLE.
- Serial output:
  - SerialValid is a register set in every cycle that follows a shift-command cycle, i.e. cycles 3..N+2.
  - SerialBit = RegShiftOut, passed through combinationally.
- Done=1 in DRAIN, i.e. the same cycle as the last SerialValid.
- N=0: LOAD, then DRAIN with Done=1 and no SerialValid.
- Step counter counts down from N. SHIFT exits when the counter reaches 1 while a shift is issued.
- Abort in LOAD, SHIFT or DRAIN:
  - Next state is CLEAR, with RegClear=1 for one cycle, then IDLE.
  - No further shift commands; SerialValid forced 0 from the CLEAR cycle; Done not asserted.
- Abort in IDLE is ignored. ReqValid and Abort together in IDLE: the request is accepted.
- Abort in CLEAR: no effect.
- Asynchronous ResetN mid-transfer: immediate return to IDLE, all outputs at reset values; no RegClear pulse is issued.
- Back-to-back: ReqValid held high is accepted in the first IDLE cycle. Minimum period is N+3 cycles.

Optional Feature:
- Macro SR_CTRL_PARITY_EN.
- Defined:
  - A PARITY state is inserted between SHIFT and DRAIN. It issues no shift command.
  - An XOR accumulator over every emitted SerialBit is cleared on accept.
  - DRAIN presents SerialValid=1 with SerialBit = accumulator, the even-parity bit of the N data bits. Done is asserted in that cycle.
  - Total transfer is N+4 cycles. For N=0 the parity bit 0 is emitted.
- Undefined: no PARITY state, no accumulator; timing exactly as in Behaviour.

Decomposition:
- Package sr_ctrl_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, PARITY, DRAIN, CLEAR);
  - constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1;
  - function clamp_count.
- One sub-module, sr_step_counter: loadable down-counter with a terminal-count flag (is-one).

Test Plan:
- ReqData=4'b1011, ReqDir=0, ReqCount=4, ReqFill=0 -> RegLoad at cycle 1; RegShiftRight cycles 2–5; SerialBit 1,1,0,1 on cycles 3–6; Done at cycle 6; final register value 0000.
- Same word, ReqDir=1, ReqFill=1 -> SerialBit 1,0,1,1; final register 1111.
- ReqCount=0 and ReqCount=7 -> Done at cycle 2, no SerialValid; count 7 clamped to 4 shifts, Done at cycle 6.
- Abort asserted at cycle 3 of a count-4 transfer -> CLEAR at cycle 4 with RegClear=1; IDLE with ReqReady=1 at cycle 5; no Done; register 0000.
- ResetN low at cycle 3 mid-transfer -> all outputs 0 and ReqReady=1 immediately. A new request after release completes normally.
- Parity build, 4'b1011 right, count 4 -> bits 1,1,0,1, then parity bit 1 with Done in the same cycle, total 8 cycles.
